// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debounce scheduler.
package debounce_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   // Width of the per-channel stability counter.
   localparam int CNT_W = 4;

   // Width of a channel index: at least one bit, even for a single channel.
   function automatic int cw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_scheduler_rr_event_arbiter.sv
// Round-robin selector over the pending-event vector. Purely combinational;
// the search start pointer lives in the caller and is advanced past each grant.
module rr_event_arbiter
   import debounce_pkg::*;
#(
   parameter int  CHANNELS = 4,
   localparam int CW       = cw_of(CHANNELS)
) (
   input  logic [CHANNELS-1:0] pend,
   input  logic [CW-1:0]       search_from,
   input  logic                grant_en,
   output logic [CW-1:0]       grant_idx,
   output logic                found
);

   // First pending channel at or after search_from, wrapping modulo CHANNELS.
   always_comb begin
      int c;
      c         = 0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         c = (int'(search_from) + k) % CHANNELS;
         if (!found && grant_en && pend[CW'(c)]) begin
            found     = 1'b1;
            grant_idx = CW'(c);
         end
      end
   end

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel debouncer: one shared tick divider and one shared stability
// check, time-multiplexed over all channels. Level changes become per-channel
// pending events that are handed out round-robin on a valid/ready port.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int  CHANNELS     = 4,
   parameter int  DIVIDER      = 10,
   parameter int  STABLE_TICKS = 3,
   localparam int CW           = cw_of(CHANNELS)
) (
   input  logic                clk_in,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] signal_in,
   output logic [CHANNELS-1:0] level_out,
   output logic                tick_out,
   output logic                event_valid,
   input  logic                event_ready,
   output logic [CW-1:0]       event_chan,
   output logic                event_rise,
   output logic                overrun_out
);

   localparam int DIV_W = $clog2(DIVIDER);

   // A scan takes CHANNELS cycles and must finish before the next tick.
   if (DIVIDER < CHANNELS + 1) begin : g_bad_divider
      $error("debounce_scheduler: DIVIDER must be at least CHANNELS+1");
   end
   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("debounce_scheduler: CHANNELS must be in 1..16");
   end
   if (STABLE_TICKS < 1 || STABLE_TICKS > 15) begin : g_bad_stable
      $error("debounce_scheduler: STABLE_TICKS must be in 1..15");
   end

   logic [DIV_W-1:0]    div_cnt;
   logic                tick;
   logic [CHANNELS-1:0] sync_p0;
   logic [CHANNELS-1:0] sync_p1;
   scan_state_t         state;
   scan_state_t         state_nxt;
   logic [CW-1:0]       idx;
   logic [CW-1:0]       idx_nxt;
   logic [CNT_W-1:0]    cnt [CHANNELS];
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] dir;
   logic [CW-1:0]       rr_ptr;
   logic                load_en;
   logic                found;
   logic [CW-1:0]       grant_idx;
   logic                scan_en;
   logic                differs;
   logic                flip;
   logic [CNT_W-1:0]    cnt_inc;
   logic [CHANNELS-1:0] set_vec;
   logic [CHANNELS-1:0] clr_vec;

   assign tick      = (div_cnt == DIV_W'(DIVIDER - 1));
   assign tick_out  = tick;
   assign level_out = level;

   // Free-running scan divider, 0..DIVIDER-1.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n)  div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   // Two-flop synchroniser for the raw pins.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= signal_in;
         sync_p1 <= sync_p0;
      end
   end

   // Scan FSM state and channel index registers.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Scan FSM next state: a tick starts a sweep of one channel per cycle.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (tick) begin
               state_nxt = SCAN;
               idx_nxt   = '0;
            end
         end
         SCAN: begin
            if (idx == CW'(CHANNELS - 1)) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Shared stability check for the channel under scan, plus set/clear masks.
   always_comb begin
      scan_en = (state == SCAN);
      differs = (sync_p1[idx] != level[idx]);
      cnt_inc = cnt[idx] + 1'b1;
      flip    = scan_en && differs && (cnt_inc == CNT_W'(STABLE_TICKS));
      set_vec = '0;
      clr_vec = '0;
      if (flip)  set_vec[idx]       = 1'b1;
      if (found) clr_vec[grant_idx] = 1'b1;
   end

   // Per-channel stability counters and debounced levels.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
         level <= '0;
      end else if (scan_en) begin
         if (!differs) begin
            cnt[idx] <= '0;
         end else if (cnt_inc == CNT_W'(STABLE_TICKS)) begin
            level[idx] <= sync_p1[idx];
            cnt[idx]   <= '0;
         end else begin
            cnt[idx] <= cnt_inc;
         end
      end
   end

   // Pending events: a new flip wins over a same-cycle grant of that channel;
   // a flip on a still-pending, ungranted channel is an overrun.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         pend        <= '0;
         dir         <= '0;
         overrun_out <= 1'b0;
      end else begin
         pend <= (pend & ~clr_vec) | set_vec;
         if (flip) dir[idx] <= sync_p1[idx];
         if (flip && pend[idx] && !clr_vec[idx]) overrun_out <= 1'b1;
      end
   end

   assign load_en = !event_valid || event_ready;

   rr_event_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arb (
      .pend        (pend),
      .search_from (rr_ptr),
      .grant_en    (load_en),
      .grant_idx   (grant_idx),
      .found       (found)
   );

   // Event output register; rr_ptr holds where the next search begins.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         event_valid <= 1'b0;
         event_chan  <= '0;
         event_rise  <= 1'b0;
         rr_ptr      <= '0;
      end else if (load_en) begin
         if (found) begin
            event_valid <= 1'b1;
            event_chan  <= grant_idx;
            event_rise  <= dir[grant_idx];
            rr_ptr      <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
         end else begin
            event_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios followed by random pin
// activity, every cycle compared against a cycle-count based reference model.
module tb_debounce_scheduler;

   localparam int CH  = 4;
   localparam int DIV = 10;
   localparam int ST  = 3;

   logic          clk_in = 1'b0;
   logic          reset_n;
   logic [CH-1:0] signal_in;
   logic [CH-1:0] level_out;
   logic          tick_out;
   logic          event_valid;
   logic          event_ready;
   logic [1:0]    event_chan;
   logic          event_rise;
   logic          overrun_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int            m_div;
   bit            m_started;
   logic [CH-1:0] m_s1, m_s2, m_level, m_pend, m_dir;
   int            m_cnt [CH];
   bit            m_ev_valid, m_ev_rise, m_over;
   int            m_ev_chan;
   int            m_next;

   always #5 clk_in = ~clk_in;

   debounce_scheduler #(
      .CHANNELS     (CH),
      .DIVIDER      (DIV),
      .STABLE_TICKS (ST)
   ) dut (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .signal_in   (signal_in),
      .level_out   (level_out),
      .tick_out    (tick_out),
      .event_valid (event_valid),
      .event_ready (event_ready),
      .event_chan  (event_chan),
      .event_rise  (event_rise),
      .overrun_out (overrun_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_div = 0; m_started = 0;
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_dir = '0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      m_ev_valid = 0; m_ev_rise = 0; m_ev_chan = 0; m_over = 0; m_next = 0;
   endtask

   // Scans are implied by the cycle count: channel k is examined on the
   // edge where the divider phase equals k, once the first tick has passed.
   task automatic model_step();
      logic [CH-1:0] old_s2, old_pend, old_dir;
      int set_ch, gnt, c;
      old_s2 = m_s2; old_pend = m_pend; old_dir = m_dir;
      set_ch = -1; gnt = -1;
      if (m_started && m_div < CH) begin
         if (old_s2[m_div] == m_level[m_div]) m_cnt[m_div] = 0;
         else if (m_cnt[m_div] + 1 == ST) begin
            m_level[m_div] = old_s2[m_div];
            m_cnt[m_div]   = 0;
            set_ch         = m_div;
         end else m_cnt[m_div] = m_cnt[m_div] + 1;
      end
      if (!m_ev_valid || event_ready) begin
         for (int k = 0; k < CH; k++) begin
            c = (m_next + k) % CH;
            if (gnt < 0 && old_pend[c]) gnt = c;
         end
         if (gnt >= 0) begin
            m_ev_valid = 1; m_ev_chan = gnt; m_ev_rise = old_dir[gnt];
            m_pend[gnt] = 1'b0; m_next = (gnt + 1) % CH;
         end else m_ev_valid = 0;
      end
      if (set_ch >= 0) begin
         if (old_pend[set_ch] && gnt != set_ch) m_over = 1;
         m_pend[set_ch] = 1'b1;
         m_dir[set_ch]  = old_s2[set_ch];
      end
      m_s2 = m_s1; m_s1 = signal_in;
      if (m_div == DIV - 1) begin m_div = 0; m_started = 1; end
      else m_div = m_div + 1;
   endtask

   task automatic cmp_all();
      check("tick", tick_out, (m_div == DIV - 1));
      check("level", level_out, m_level);
      check("valid", event_valid, m_ev_valid);
      if (m_ev_valid) begin
         check("chan", event_chan, m_ev_chan);
         check("rise", event_rise, m_ev_rise);
      end
      check("overrun", overrun_out, m_over);
   endtask

   task automatic step();
      @(posedge clk_in);
      if (reset_n) model_step(); else model_reset();
      @(negedge clk_in);
      cmp_all();
   endtask

   task automatic wait_level(input int i, input logic v, input int budget, input string tag);
      int k = 0;
      while (level_out[i] !== v && k < budget) begin step(); k++; end
      check(tag, level_out[i], v);
   endtask

   task automatic wait_tick(input int budget);
      int k = 0;
      while (tick_out !== 1'b1 && k < budget) begin step(); k++; end
      check("wait_tick", tick_out, 1'b1);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (event_valid !== 1'b1 && k < budget) begin step(); k++; end
      check("wait_valid", event_valid, 1'b1);
   endtask

   initial begin
      bit saw;
      int ch;
      reset_n = 1'b0; signal_in = '0; event_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_in);
      check("rst_level", level_out, 4'b0000);
      check("rst_valid", event_valid, 1'b0);
      check("rst_overrun", overrun_out, 1'b0);
      check("rst_tick", tick_out, 1'b0);
      check("rst_chan", event_chan, 2'd0);
      check("rst_rise", event_rise, 1'b0);

      // Tick cadence after release
      reset_n = 1'b1;
      check("tick_n0", tick_out, 1'b0);
      for (int n = 1; n < 30; n++) begin
         step();
         check("tick_cycle", tick_out, (n % 10 == 9));
      end

      // Single rise on channel 2, consumed immediately
      event_ready = 1'b1;
      signal_in[2] = 1'b1;
      wait_level(2, 1'b1, 40, "ch2_rise_level");
      check("ch2_pend_lag", event_valid, 1'b0);
      step();
      check("ch2_valid", event_valid, 1'b1);
      check("ch2_chan", event_chan, 2'd2);
      check("ch2_rise", event_rise, 1'b1);
      step();
      check("ch2_consumed", event_valid, 1'b0);

      // Short glitch on channel 1 is filtered out
      signal_in[1] = 1'b1;
      repeat (15) step();
      signal_in[1] = 1'b0;
      saw = 0;
      repeat (50) begin step(); if (event_valid) saw = 1; end
      check("glitch_level", level_out[1], 1'b0);
      check("glitch_event", saw, 1'b0);

      // Channels 0 and 3 rise in one scan while the consumer stalls
      event_ready = 1'b0;
      wait_tick(20);
      repeat (6) step();
      signal_in[0] = 1'b1; signal_in[3] = 1'b1;
      wait_level(3, 1'b1, 40, "ch3_rise_level");
      check("ch0_rise_level", level_out[0], 1'b1);
      step();
      check("pair_valid", event_valid, 1'b1);
      check("pair_first_chan", event_chan, 2'd0);
      repeat (20) begin
         step();
         check("hold_chan", event_chan, 2'd0);
         check("hold_valid", event_valid, 1'b1);
      end
      event_ready = 1'b1;
      step();
      check("pair_second_valid", event_valid, 1'b1);
      check("pair_second_chan", event_chan, 2'd3);
      check("pair_second_rise", event_rise, 1'b1);
      step();
      check("pair_drained", event_valid, 1'b0);

      // Channel 1 rises and falls while stuck behind channel 0's event
      event_ready = 1'b0;
      wait_tick(20);
      repeat (6) step();
      signal_in[0] = 1'b0; signal_in[1] = 1'b1;
      wait_level(1, 1'b1, 40, "ovr_rise_level");
      check("ovr_not_yet", overrun_out, 1'b0);
      signal_in[1] = 1'b0;
      wait_level(1, 1'b0, 40, "ovr_fall_level");
      check("ovr_set", overrun_out, 1'b1);
      check("ovr_head_chan", event_chan, 2'd0);
      check("ovr_head_rise", event_rise, 1'b0);
      event_ready = 1'b1;
      step();
      check("ovr_ch1_valid", event_valid, 1'b1);
      check("ovr_ch1_chan", event_chan, 2'd1);
      check("ovr_ch1_rise", event_rise, 1'b0);
      step();
      check("ovr_drained", event_valid, 1'b0);
      check("ovr_sticky", overrun_out, 1'b1);

      // Reset mid-scan with an event on the port
      event_ready = 1'b0;
      signal_in[2] = 1'b0;
      wait_valid(40);
      wait_tick(20);
      step();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("arst_level", level_out, 4'b0000);
      check("arst_valid", event_valid, 1'b0);
      check("arst_overrun", overrun_out, 1'b0);
      check("arst_tick", tick_out, 1'b0);
      check("arst_chan", event_chan, 2'd0);
      signal_in = '0;
      repeat (2) step();
      reset_n = 1'b1;
      saw = 0;
      repeat (40) begin step(); if (event_valid) saw = 1; end
      check("no_stale_event", saw, 1'b0);

      // Random pin activity and consumer back-pressure
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            ch = $urandom_range(0, CH - 1);
            signal_in[ch] = ~signal_in[ch];
         end
         event_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
